i2c_slave_regs: RTL and testbench

- I2C target (responder) paired with the team's I2C master. It sits on the same open-drain `scl`/`sda` pair as the master, in the top level or the testbench.
- Decodes START and STOP, matches a 7-bit address and ACKs it.
- Writes: the master loads a register pointer, then data bytes into a small register file.
- Reads: the target returns register bytes with pointer auto-increment.
- Lets the master be exercised end-to-end in simulation and on board, for example by driving LEDs from the register file.

---
 rtl/i2c_defs.sv | 20 ++
 rtl/i2c_line_sync.sv | 45 ++++
 rtl/i2c_slave_regs.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_defs.sv
// Shared I2C encodings for the register target and the master's bench checks.
// Pure definitions: no latency and no flow control.
package i2c_defs;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_ADDR  = 3'd1,
        ACK_ADDR = 3'd2,
        RX_DATA  = 3'd3,
        ACK_DATA = 3'd4,
        TX_DATA  = 3'd5,
        RX_ACK   = 3'd6
    } state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises scl/sda and flags SCL edges plus START/STOP conditions.
// Events appear 3 clk after the pin changes; no backpressure, the bus cannot be stalled.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_m, sda_m, scl_p, sda_p;

    // Idle bus is high, so resetting to 1 keeps reset release from looking like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_m     <= 1'b1;
            sda_m     <= 1'b1;
            scl_s     <= 1'b1;
            sda_s     <= 1'b1;
            scl_p     <= 1'b1;
            sda_p     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_m     <= scl;
            sda_m     <= sda;
            scl_s     <= scl_m;
            sda_s     <= sda_m;
            scl_p     <= scl_s;
            sda_p     <= sda_s;
            scl_rise  <= scl_s & ~scl_p;
            scl_fall  <= ~scl_s & scl_p;
            start_det <= scl_s & scl_p & sda_p & ~sda_s;
            stop_det  <= scl_s & scl_p & ~sda_p & sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a small pointer-addressed register file, auto-increment on read and write.
// SDA drive changes 1 clk after a detected SCL fall (~4 clk after the pin); never stretches SCL.
module i2c_slave_regs
    import i2c_defs::*;
#(
    parameter logic [6:0] ADDR  = 7'h50,
    parameter int         NREGS = 4,
    parameter int         PTRW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scl,
    inout  wire                sda,
    output logic [8*NREGS-1:0] regs,
    output logic               wr_stb,
    output logic [PTRW-1:0]    wr_idx,
    output logic               busy
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [6:0]        shreg_q, shreg_d;
    logic [7:0]        txbyte_q, txbyte_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              first_q, first_d;
    logic              tx_wait_q, tx_wait_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              we;
    logic [8*NREGS-1:0] regs_q;
    logic [7:0]        rx_byte, cur_byte;
    logic              rise, fall;

    // An edge is only honoured if the level still agrees, filtering sub-clk runt pulses.
    assign rise     = scl_rise & scl_s;
    assign fall     = scl_fall & ~scl_s;
    assign rx_byte  = {shreg_q, sda_s};
    assign cur_byte = regs_q[{ptr_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        txbyte_d  = txbyte_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        first_d   = first_q;
        tx_wait_d = tx_wait_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        we        = 1'b0;
        if (start_det) begin
            state_d   = RX_ADDR;
            cnt_d     = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            tx_wait_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            tx_wait_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                RX_ADDR: if (rise) begin
                    shreg_d = rx_byte[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == ADDR) begin
                            state_d = ACK_ADDR;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                // oe_q doubles as the phase flag: first fall starts the ACK, second ends it.
                ACK_ADDR: if (fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        cnt_d = 3'd0;
                        if (rw_q == RW_READ) begin
                            state_d  = TX_DATA;
                            txbyte_d = cur_byte;
                            oe_d     = ~cur_byte[7];
                        end else begin
                            state_d = RX_DATA;
                            oe_d    = 1'b0;
                            first_d = 1'b1;
                        end
                    end
                end
                RX_DATA: if (rise) begin
                    shreg_d = rx_byte[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ACK_DATA;
                        if (first_q) begin
                            ptr_d   = rx_byte[PTRW-1:0];
                            first_d = 1'b0;
                        end else begin
                            we    = 1'b1;
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                ACK_DATA: if (fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = RX_DATA;
                    end
                end
                TX_DATA: if (fall) begin
                    if (tx_wait_q) begin
                        txbyte_d  = cur_byte;
                        oe_d      = ~cur_byte[7];
                        cnt_d     = 3'd0;
                        tx_wait_d = 1'b0;
                    end else if (cnt_q == 3'd7) begin
                        oe_d    = 1'b0;
                        state_d = RX_ACK;
                    end else begin
                        cnt_d    = cnt_q + 3'd1;
                        txbyte_d = {txbyte_q[6:0], 1'b0};
                        oe_d     = ~txbyte_q[6];
                    end
                end
                // After an ACK the next byte is loaded on the following fall, once ptr has moved.
                RX_ACK: if (rise) begin
                    ptr_d = ptr_q + 1'b1;
                    if (sda_s == ACK) begin
                        state_d   = TX_DATA;
                        tx_wait_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        oe_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            shreg_q   <= 7'd0;
            txbyte_q  <= 8'd0;
            ptr_q     <= '0;
            rw_q      <= RW_WRITE;
            first_q   <= 1'b0;
            tx_wait_q <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            regs_q    <= '0;
            wr_stb    <= 1'b0;
            wr_idx    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            txbyte_q  <= txbyte_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            tx_wait_q <= tx_wait_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_stb    <= we;
            if (we) begin
                regs_q[{ptr_q, 3'b000} +: 8] <= rx_byte;
                wr_idx                       <= ptr_q;
            end
        end
    end

    // Gating with reset releases the line combinationally the moment reset asserts.
    assign sda  = (oe_q && reset) ? 1'b0 : 1'bz;
    assign regs = regs_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench: bit-banged I2C master, register-file reference model, table vectors plus random traffic.
module tb_i2c_slave_regs;

    localparam int Q = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic [31:0] regs;
    logic        wr_stb;
    logic [1:0]  wr_idx;
    logic        busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regs #(.ADDR(7'h50), .NREGS(4), .PTRW(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .scl    (scl),
        .sda    (sda),
        .regs   (regs),
        .wr_stb (wr_stb),
        .wr_idx (wr_idx),
        .busy   (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register array and pointer, updated from the protocol rules.
    logic [7:0] m_regs [4];
    int         m_ptr;

    int         stb_cnt = 0;
    logic [1:0] stb_idx_q [$];

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_cnt++;
            stb_idx_q.push_back(wr_idx);
        end
    end

    function automatic logic [31:0] m_flat();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic sda_line();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        m_low = 1'b0; wq(Q);
        scl = 1'b1;   wq(Q);
        m_low = 1'b1; wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic m_stop();
        m_low = 1'b1; wq(Q);
        scl = 1'b1;   wq(Q);
        m_low = 1'b0; wq(Q);
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; wq(Q);
        scl = 1'b1; wq(2*Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; wq(Q);
        scl = 1'b1;   wq(Q);
        b = sda_line(); wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic [7:0] t;
        logic       bb;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bb);
            t[i] = bb;
        end
        d = t;
        send_bit(ack_bit);
    endtask

    // b[0] is the pointer byte, b[1..n-1] are data bytes.
    task automatic do_write(input logic [7:0] addr, input logic [7:0] b [4], input int n,
                            input logic exp_hit, input string tag);
        logic       a;
        logic [1:0] exp_idx [$];
        int         stb0;
        stb0 = stb_cnt;
        stb_idx_q.delete();
        m_start();
        write_byte(addr, a);
        check({tag, " addr_ack"}, {31'd0, a}, exp_hit ? 32'd0 : 32'd1);
        check({tag, " busy_after_addr"}, {31'd0, busy}, {31'd0, exp_hit});
        for (int k = 0; k < n; k++) begin
            write_byte(b[k], a);
            check({tag, " data_ack"}, {31'd0, a}, exp_hit ? 32'd0 : 32'd1);
            if (exp_hit) begin
                if (k == 0) begin
                    m_ptr = b[k] % 4;
                end else begin
                    m_regs[m_ptr] = b[k];
                    exp_idx.push_back(m_ptr[1:0]);
                    m_ptr = (m_ptr + 1) % 4;
                end
            end
        end
        m_stop();
        wq(4);
        check({tag, " regs"}, regs, m_flat());
        check({tag, " stb_count"}, stb_cnt - stb0, exp_idx.size());
        for (int k = 0; k < exp_idx.size() && k < stb_idx_q.size(); k++)
            check({tag, " wr_idx"}, {30'd0, stb_idx_q[k]}, {30'd0, exp_idx[k]});
        check({tag, " busy_after_stop"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
        logic       a;
        logic [7:0] d;
        m_start();
        if (set_ptr) begin
            write_byte(8'hA0, a);
            check({tag, " wr_addr_ack"}, {31'd0, a}, 32'd0);
            write_byte(p, a);
            check({tag, " ptr_ack"}, {31'd0, a}, 32'd0);
            m_ptr = p % 4;
            m_start();
        end
        write_byte(8'hA1, a);
        check({tag, " rd_addr_ack"}, {31'd0, a}, 32'd0);
        for (int k = 0; k < n; k++) begin
            read_byte(d, (k == n - 1) ? 1'b1 : 1'b0);
            check({tag, " rd_byte"}, {24'd0, d}, {24'd0, m_regs[m_ptr]});
            m_ptr = (m_ptr + 1) % 4;
        end
        wq(2);
        check({tag, " sda_released"}, {31'd0, sda_line()}, 32'd1);
        check({tag, " busy_after_nack"}, {31'd0, busy}, 32'd0);
        m_stop();
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  p;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        hit;
        logic [31:0] exp_regs;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bb [4];
        logic [6:0] a7;
        logic       a;
        int         n;

        // Expected register images assume the state left by the opening write and read.
        vecs[0] = '{8'hA2, 8'h55, 8'h11, 8'h22, 1'b0, 32'h003CA500};
        vecs[1] = '{8'hA0, 8'h03, 8'h77, 8'h88, 1'b1, 32'h773CA588};
        vecs[2] = '{8'hA0, 8'hFE, 8'h99, 8'h66, 1'b1, 32'h6699A588};
        vecs[3] = '{8'hA4, 8'h00, 8'h12, 8'h34, 1'b0, 32'h6699A588};
        vecs[4] = '{8'hA0, 8'h05, 8'hC3, 8'h5A, 1'b1, 32'h665AC388};

        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ptr = 0;

        wq(4);
        check("reset regs", regs, 32'd0);
        check("reset wr_stb", {31'd0, wr_stb}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset sda", {31'd0, sda_line()}, 32'd1);
        reset = 1'b1;
        wq(4);

        bb = '{8'h01, 8'hA5, 8'h3C, 8'h00};
        do_write(8'hA0, bb, 3, 1'b1, "plan_write");
        check("plan_write regs_const", regs, 32'h003CA500);
        // Current-address read: returns regs[3] only if the pointer ended at 3.
        do_read(1'b0, 8'h00, 1, "ptr_after_write");

        for (int i = 0; i < 5; i++) begin
            bb = '{vecs[i].p, vecs[i].d0, vecs[i].d1, 8'h00};
            do_write(vecs[i].addr, bb, 3, vecs[i].hit, "vec");
            check("vec regs_table", regs, vecs[i].exp_regs);
        end

        do_read(1'b1, 8'h03, 2, "read_wrap");

        // STOP after four data bits: partial byte must be dropped.
        m_start();
        write_byte(8'hA0, a);
        write_byte(8'h00, a);
        m_ptr = 0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        m_stop();
        wq(4);
        check("stop_mid regs", regs, m_flat());
        check("stop_mid busy", {31'd0, busy}, 32'd0);
        check("stop_mid sda", {31'd0, sda_line()}, 32'd1);
        bb = '{8'h00, 8'h5A, 8'h00, 8'h00};
        do_write(8'hA0, bb, 2, 1'b1, "after_stop_mid");

        // Reset while the target drives a 0 bit of regs[1]=C3 (bit 5 is the first zero).
        m_start();
        write_byte(8'hA0, a);
        write_byte(8'h01, a);
        m_start();
        write_byte(8'hA1, a);
        check("rst_rd addr_ack", {31'd0, a}, 32'd0);
        recv_bit(a);
        recv_bit(a);
        m_low = 1'b0;
        wq(Q);
        check("rst_rd driving_low", {31'd0, sda_line()}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_rd sda_released", {31'd0, sda_line()}, 32'd1);
        check("rst_rd regs", regs, 32'd0);
        check("rst_rd busy", {31'd0, busy}, 32'd0);
        scl = 1'b1;
        wq(Q);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        wq(Q);
        bb = '{8'h02, 8'hDE, 8'hAD, 8'h00};
        do_write(8'hA0, bb, 3, 1'b1, "post_reset_write");
        do_read(1'b1, 8'h02, 2, "post_reset_read");

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                a7 = 7'h50;
                if ($urandom_range(0, 3) == 0) a7 = 7'($urandom);
                n  = $urandom_range(1, 4);
                for (int k = 0; k < 4; k++) bb[k] = 8'($urandom);
                do_write({a7, 1'b0}, bb, n, (a7 == 7'h50), "rand_write");
            end else begin
                do_read(1'($urandom), 8'($urandom), $urandom_range(1, 5), "rand_read");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
